// File: rtl/recram_arb.sv
// Arbiter giving a CPU port and a recorder port shared access to a synchronous recording RAM.
// Optional starvation guard for the CPU is enabled by defining RECRAM_ARB_STARVE_EN.
module recram_arb #(
    parameter int ADR_W      = 12,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [ADR_W-1:0] cpu_adr,
    input  logic [7:0]       cpu_wdata,
    output logic             cpu_ack,
    output logic [7:0]       cpu_rdata,

    input  logic             rec_req,
    input  logic             rec_we,
    input  logic [ADR_W-1:0] rec_adr,
    input  logic [7:0]       rec_wdata,
    output logic             rec_ack,
    output logic [7:0]       rec_rdata,

    output logic [ADR_W-1:0] ram_adr,
    output logic             ram_we,
    output logic [7:0]       ram_wdata,
    input  logic [7:0]       ram_rdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0] state;
    logic       owner_cpu;
    logic       any_req;
    logic       grant_cpu;
    logic [7:0] cpu_rdata_q;
    logic [7:0] rec_rdata_q;

    assign any_req = cpu_req | rec_req;

`ifdef RECRAM_ARB_STARVE_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;
    logic       starve_hit;

    assign starve_hit = (starve_cnt == STARVE_LIM);
    assign grant_cpu  = cpu_req & (~rec_req | starve_hit);

    // Counts recorder wins the waiting CPU has suffered; a full count hands the CPU the next tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (state == ST_IDLE) begin
            if (!cpu_req || grant_cpu) begin
                starve_cnt <= 4'd0;
            end else if (rec_req && !starve_hit) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
`else
    logic [3:0] unused_starve_max;

    assign unused_starve_max = 4'(STARVE_MAX);
    assign grant_cpu         = cpu_req & ~rec_req;
`endif

    // Three-cycle access: latch winner and RAM command, let the RAM read, then acknowledge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            owner_cpu   <= 1'b0;
            ram_adr     <= '0;
            ram_we      <= 1'b0;
            ram_wdata   <= 8'd0;
            cpu_ack     <= 1'b0;
            rec_ack     <= 1'b0;
            cpu_rdata_q <= 8'd0;
            rec_rdata_q <= 8'd0;
        end else begin
            cpu_ack <= 1'b0;
            rec_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ram_we <= 1'b0;
                    if (any_req) begin
                        owner_cpu <= grant_cpu;
                        ram_adr   <= grant_cpu ? cpu_adr   : rec_adr;
                        ram_we    <= grant_cpu ? cpu_we    : rec_we;
                        ram_wdata <= grant_cpu ? cpu_wdata : rec_wdata;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    ram_we  <= 1'b0;
                    cpu_ack <= owner_cpu;
                    rec_ack <= ~owner_cpu;
                    state   <= ST_RESP;
                end
                ST_RESP: begin
                    ram_we <= 1'b0;
                    if (owner_cpu) begin
                        cpu_rdata_q <= ram_rdata;
                    end else begin
                        rec_rdata_q <= ram_rdata;
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    ram_we <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM data arrives in the ack cycle, so it is passed straight through until the register catches it.
    assign cpu_rdata = cpu_ack ? ram_rdata : cpu_rdata_q;
    assign rec_rdata = rec_ack ? ram_rdata : rec_rdata_q;

endmodule

// File: tb/tb_recram_arb.sv
// Scoreboard testbench for recram_arb with a behavioural 4096-byte synchronous RAM.
// Grant-order expectations follow RECRAM_ARB_STARVE_EN when it is defined for the build.
module tb_recram_arb;

    localparam int ADR_W      = 12;
    localparam int STARVE_MAX = 4;

    typedef struct packed {
        logic        is_cpu;
        logic        chk;
        logic [7:0]  data;
        logic [31:0] due;
    } sb_entry_t;

    logic             clk;
    logic             reset;
    logic             cpu_req, cpu_we, rec_req, rec_we;
    logic [ADR_W-1:0] cpu_adr, rec_adr, ram_adr;
    logic [7:0]       cpu_wdata, rec_wdata, ram_wdata, ram_rdata;
    logic             cpu_ack, rec_ack, ram_we;
    logic [7:0]       cpu_rdata, rec_rdata;

    logic [7:0]       mem [0:4095];
    sb_entry_t        sb_q [$];
    int               cyc   = 0;
    int               tests = 0;
    int               fails = 0;

    recram_arb #(.ADR_W(ADR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .rec_req(rec_req), .rec_we(rec_we), .rec_adr(rec_adr), .rec_wdata(rec_wdata),
        .rec_ack(rec_ack), .rec_rdata(rec_rdata),
        .ram_adr(ram_adr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Read-first synchronous RAM
    always @(posedge clk) begin
        if (ram_we) mem[ram_adr] <= ram_wdata;
        ram_rdata <= mem[ram_adr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic is_cpu, input logic req, input logic we,
                                 input logic [ADR_W-1:0] adr, input logic [7:0] wdata);
        if (is_cpu) begin
            cpu_req = req; cpu_we = we; cpu_adr = adr; cpu_wdata = wdata;
        end else begin
            rec_req = req; rec_we = we; rec_adr = adr; rec_wdata = wdata;
        end
    endtask

    task automatic expectAck(input logic is_cpu, input logic chk, input logic [7:0] data, input int due);
        sb_entry_t e;
        e.is_cpu = is_cpu; e.chk = chk; e.data = data; e.due = 32'(due);
        sb_q.push_back(e);
    endtask

    task automatic sampleAcks();
        sb_entry_t e;
        while (sb_q.size() > 0 && int'(sb_q[0].due) < cyc) begin
            e = sb_q.pop_front();
            checkOutput("ack_missing", 32'(cyc), e.due);
        end
        if (cpu_ack && rec_ack) checkOutput("dual_ack", 1, 0);
        if (cpu_ack || rec_ack) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_ack", {30'd0, cpu_ack, rec_ack}, 0);
            end else begin
                e = sb_q.pop_front();
                checkOutput("ack_port_cpu", 32'(cpu_ack), 32'(e.is_cpu));
                checkOutput("ack_cycle", 32'(cyc), e.due);
                if (e.chk) checkOutput("ack_rdata", 32'(cpu_ack ? cpu_rdata : rec_rdata), 32'(e.data));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sampleAcks();
    endtask

    initial begin
        int d;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 8'h00);
        tick(); tick();

        // Reset state
        checkOutput("rst_ram_we", 32'(ram_we), 0);
        checkOutput("rst_ram_adr", 32'(ram_adr), 0);
        checkOutput("rst_ram_wdata", 32'(ram_wdata), 0);
        checkOutput("rst_acks", {30'd0, cpu_ack, rec_ack}, 0);
        checkOutput("rst_rdata", {cpu_rdata, rec_rdata}, 0);
        reset = 1'b0;
        tick();

        // Single CPU read
        mem[12'h123] = 8'h5A;
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h123, 8'h00);
        d = cyc;
        expectAck(1'b1, 1'b1, 8'h5A, d + 2);
        tick();
        checkOutput("rd_ram_adr", 32'(ram_adr), 32'h123);
        checkOutput("rd_ram_we", 32'(ram_we), 0);
        checkOutput("rd_early_ack", 32'(cpu_ack), 0);
        tick();
        checkOutput("rd_rec_ack", 32'(rec_ack), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 12'h123, 8'h00);
        tick(); tick();
        checkOutput("rd_rdata_held", 32'(cpu_rdata), 32'h5A);

        // Recorder write to the top address, then CPU read-back
        applyStimulus(1'b0, 1'b1, 1'b1, 12'hFFF, 8'hC3);
        d = cyc;
        expectAck(1'b0, 1'b0, 8'h00, d + 2);
        tick();
        checkOutput("wr_ram_we", 32'(ram_we), 1);
        checkOutput("wr_ram_adr", 32'(ram_adr), 32'hFFF);
        checkOutput("wr_ram_wdata", 32'(ram_wdata), 32'hC3);
        tick();
        checkOutput("wr_resp_we", 32'(ram_we), 0);
        checkOutput("wr_cpu_rdata_kept", 32'(cpu_rdata), 32'h5A);
        applyStimulus(1'b0, 1'b0, 1'b0, 12'hFFF, 8'h00);
        tick();
        checkOutput("wr_idle_we", 32'(ram_we), 0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 12'hFFF, 8'h00);
        expectAck(1'b1, 1'b1, 8'hC3, cyc + 2);
        tick(); tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 12'hFFF, 8'h00);
        tick(); tick();

        // Back-to-back CPU writes with the request held
        applyStimulus(1'b1, 1'b1, 1'b1, 12'h010, 8'h3C);
        d = cyc;
        for (int i = 0; i < 3; i++) expectAck(1'b1, 1'b0, 8'h00, d + 2 + 3 * i);
        for (int k = 1; k <= 8; k++) begin
            tick();
            checkOutput($sformatf("b2b_we_%0d", k), 32'(ram_we), 32'(k == 1 || k == 4 || k == 7));
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 12'h010, 8'h00);
        tick(); tick();
        checkOutput("b2b_mem", 32'(mem[12'h010]), 32'h3C);

        // Both ports requesting continuously
        mem[12'h200] = 8'hA1;
        mem[12'h300] = 8'hB2;
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h200, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'h300, 8'h00);
        d = cyc;
`ifdef RECRAM_ARB_STARVE_EN
        for (int i = 0; i < 10; i++)
            expectAck((i % 5) == 4, 1'b1, ((i % 5) == 4) ? 8'hA1 : 8'hB2, d + 2 + 3 * i);
        for (int k = 0; k < 29; k++) tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 12'h200, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h300, 8'h00);
        tick(); tick(); tick();
`else
        for (int i = 0; i < 6; i++) expectAck(1'b0, 1'b1, 8'hB2, d + 2 + 3 * i);
        for (int k = 0; k < 17; k++) tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h300, 8'h00);
        expectAck(1'b1, 1'b1, 8'hA1, cyc + 3);
        tick(); tick(); tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 12'h200, 8'h00);
        tick(); tick();
`endif
        checkOutput("arb_cpu_rdata", 32'(cpu_rdata), 32'hA1);

        // Reset during the ACCESS cycle of a CPU write
        applyStimulus(1'b1, 1'b1, 1'b1, 12'h055, 8'h77);
        tick();
        checkOutput("rst_mid_pre_we", 32'(ram_we), 1);
        reset = 1'b1;
        #1;
        checkOutput("rst_mid_we", 32'(ram_we), 0);
        checkOutput("rst_mid_adr", 32'(ram_adr), 0);
        checkOutput("rst_mid_rdata", {cpu_rdata, rec_rdata}, 0);
        tick();
        checkOutput("rst_mid_ack", {30'd0, cpu_ack, rec_ack}, 0);
        checkOutput("rst_mid_mem", 32'(mem[12'h055]), 0);
        tick();
        reset = 1'b0;
        expectAck(1'b1, 1'b0, 8'h00, cyc + 2);
        tick();
        checkOutput("rst_post_we", 32'(ram_we), 1);
        checkOutput("rst_post_adr", 32'(ram_adr), 32'h055);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 12'h055, 8'h00);
        for (int k = 0; k < 5; k++) tick();
        checkOutput("rst_post_mem", 32'(mem[12'h055]), 32'h77);

        checkOutput("sb_leftover", 32'(sb_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/recram_arb.md
RECRAM_ARB -- requirements
Module: recram_arb

Interface
REQ-001 Parameter: ADR_W, 12, RAM address width (4096-byte recording RAM).
REQ-002 Parameter: STARVE_MAX, 4, consecutive recorder wins tolerated while CPU waits (1..15).
REQ-003 Clock and reset are fixed: one clock `clk`, rising edge; reset `reset` is asynchronous and active-high.
REQ-004 clk  in  1  system clock (cpuclk domain).
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 cpu_req  in  1  CPU access request, held until cpu_ack.
REQ-007 cpu_we  in  1  CPU request is a write.
REQ-008 cpu_adr  in  ADR_W  CPU address.
REQ-009 cpu_wdata  in  8  CPU write data.
REQ-010 cpu_ack  out  1  one-cycle completion pulse to the CPU.
REQ-011 cpu_rdata  out  8  CPU read data, valid from the cpu_ack cycle, held until the next CPU completion.
REQ-012 rec_req / rec_we / rec_adr / rec_wdata  in  1/1/ADR_W/8  recorder request port, same semantics as the CPU port.
REQ-013 rec_ack / rec_rdata  out  1/8  recorder completion pulse and read data, same semantics as the CPU port.
REQ-014 ram_adr  out  ADR_W  registered RAM address.
REQ-015 ram_we  out  1  registered RAM write strobe.
REQ-016 ram_wdata  out  8  registered RAM write data.
REQ-017 ram_rdata  in  8  synchronous RAM output, valid one cycle after ram_adr.

Function
REQ-018 FSM states: IDLE, ACCESS, RESP; IDLE->ACCESS when any req is sampled high; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-019 In IDLE, arbitration latches the winner (owner), and ram_adr/ram_we/ram_wdata are loaded from the winner's port, so they are valid throughout ACCESS.
REQ-020 ram_we is high only in ACCESS and only for a write; it is low in IDLE and RESP.
REQ-021 In RESP, the owner's ack is high for exactly one cycle and the owner's rdata register is loaded from ram_rdata; the other port's ack and rdata are unchanged.
REQ-022 Latency: req first sampled in IDLE at cycle T -> ack at T+2; next arbitration at T+3; peak throughput is one access per 3 cycles.
REQ-023 Requests are not sampled in ACCESS or RESP; a req still high in the IDLE after its ack is a new request.
REQ-024 Priority: recorder wins a tie unless the starve condition holds (REQ-026).
REQ-025 A lone requester always wins.
REQ-026 Starvation counter (ADR-independent, 4 bits):
  - increments on each recorder grant made while cpu_req is high;
  - clears on a CPU grant or in any IDLE cycle with cpu_req low;
  - when it equals STARVE_MAX, the CPU wins the next tie;
  - saturates at STARVE_MAX.
REQ-027 Write data is not returned; rdata updates on writes too, with ram_rdata at the written address (don't-care content, deterministic update).

Reset
REQ-028 While reset is asserted, independent of clk:
  - state = IDLE;
  - ram_we = 0, ram_adr = 0, ram_wdata = 0;
  - both acks = 0, both rdata = 0;
  - starvation counter = 0.
REQ-029 Reset during ACCESS or RESP aborts the access: ram_we drops immediately and no ack is issued for the aborted request.
REQ-030 After reset release, arbitration starts on the first rising clk edge.

Configuration
REQ-031 Macro RECRAM_ARB_STARVE_EN:
  - defined: the starvation counter of REQ-026 is implemented;
  - undefined: no counter logic, and the recorder strictly wins every tie.

Verification
REQ-032 Single CPU read: RAM[0x123]=0x5A; cpu_req at T with cpu_adr=0x123, cpu_we=0 -> ram_adr=0x123 at T+1, cpu_ack and cpu_rdata=0x5A at T+2, rec_ack stays 0.
REQ-033 Recorder write: rec_req with rec_adr=0xFFF, rec_wdata=0xC3, rec_we=1 -> ram_we=1 only at T+1 with ram_adr=0xFFF, ram_wdata=0xC3; rec_ack at T+2; a later CPU read of 0xFFF returns 0xC3.
REQ-034 Simultaneous continuous requests, STARVE_MAX=4, macro defined -> grant order REC,REC,REC,REC,CPU, repeating; macro undefined -> CPU never acked while rec_req is held high.
REQ-035 Reset mid-access: assert reset during ACCESS of a write -> ram_we drops 0 asynchronously, no ack, state IDLE; after release, the held request completes exactly once.
REQ-036 Back-to-back by one requester: cpu_req held high across 3 accesses -> cpu_ack at T+2, T+5, T+8, and ram_we never high in IDLE or RESP.
